duty_step_controller: RTL and testbench

Front-end controller that sequences the 4-bit PWM duty-cycle register from the two push-buttons. It synchronises and debounces raw `btn_up`/`btn_dn`, adds hold-to-auto-repeat, and offers an automatic triangle sweep mode. It emits clean single-cycle `up`/`dn` step pulses into the duty-cycle register, which steps on their rising edges. It keeps a shadow copy of the duty value so that steps are never issued at the 0/15 limits.

---
 rtl/duty_step_controller.sv | 188 ++++++++++++++++++
 tb/tb_duty_step_controller.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/duty_step_controller.sv
// Push-button front end for the 4-bit PWM duty register: synchronise, debounce, auto-repeat,
// triangle sweep, and limit-aware single-cycle up/dn step pulses with a shadow duty copy.
module duty_step_controller #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_RATE     = 5000000,
  parameter int unsigned SWEEP_PERIOD    = 2500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_dn,
  input  logic       sweep_en,
  output logic       up,
  output logic       dn,
  output logic [3:0] duty_shadow,
  output logic       sweep_dir
);

  localparam int unsigned DebW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned RptMax = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned RptW   = $clog2(RptMax);
  localparam int unsigned SwpW   = $clog2(SWEEP_PERIOD);

  localparam logic [DebW-1:0] DebLast   = DebW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RptW-1:0] DelayLoad = RptW'(REPEAT_DELAY - 1);
  localparam logic [RptW-1:0] RateLoad  = RptW'(REPEAT_RATE - 1);
  localparam logic [SwpW-1:0] SwpLoad   = SwpW'(SWEEP_PERIOD - 1);

  typedef enum logic [2:0] {StIdle, StStep, StHold, StRepeat, StLock} state_e;

  // Bit 0 is the up button, bit 1 the down button throughout.
  logic [1:0]      btn_raw;
  logic [1:0]      sync1_q, sync2_q;
  logic [1:0]      deb_q, deb_d, deb_prev_q, deb_rise;
  logic [DebW-1:0] deb_cnt_q [2];
  logic [DebW-1:0] deb_cnt_d [2];

  state_e          state_q, state_d;
  logic            dir_q, dir_d;      // latched button: 0 = up, 1 = down
  logic [RptW-1:0] timer_q, timer_d;
  logic            fire;

  logic            sweep_en_q;
  logic [SwpW-1:0] sweep_cnt_q, sweep_cnt_d;
  logic            sweep_dir_q, sweep_dir_d;
  logic            sweep_step;

  logic            want_up, want_dn;
  logic            up_q, up_d, dn_q, dn_d;
  logic [3:0]      shadow_q, shadow_d;

  assign btn_raw  = {btn_dn, btn_up};
  assign deb_rise = deb_q & ~deb_prev_q;

  // Debounce: flip only after DEBOUNCE_CYCLES consecutive disagreeing cycles.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      deb_cnt_d[i] = '0;
      deb_d[i]     = deb_q[i];
      if (sync2_q[i] != deb_q[i]) begin
        if (deb_cnt_q[i] == DebLast) begin
          deb_d[i] = ~deb_q[i];
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + DebW'(1);
        end
      end
    end
  end

  // Manual FSM; sweep mode or both buttons down parks it in StLock.
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    timer_d = timer_q;
    fire    = 1'b0;
    if (sweep_en || (deb_q == 2'b11)) begin
      state_d = StLock;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (deb_rise[0] && !deb_q[1]) begin
            dir_d   = 1'b0;
            state_d = StStep;
          end else if (deb_rise[1] && !deb_q[0]) begin
            dir_d   = 1'b1;
            state_d = StStep;
          end
        end
        StStep: begin
          fire    = 1'b1;
          timer_d = DelayLoad;
          state_d = StHold;
        end
        StHold, StRepeat: begin
          if (!deb_q[dir_q]) begin
            state_d = StIdle;
          end else if (timer_q == '0) begin
            fire    = 1'b1;
            timer_d = RateLoad;
            state_d = StRepeat;
          end else begin
            timer_d = timer_q - RptW'(1);
          end
        end
        StLock: begin
          if (deb_q == 2'b00) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Sweep timer restarts on entry; direction turns around before stepping off a limit.
  always_comb begin
    sweep_cnt_d = sweep_cnt_q;
    sweep_dir_d = sweep_dir_q;
    sweep_step  = 1'b0;
    if (sweep_en) begin
      if (!sweep_en_q) begin
        sweep_cnt_d = SwpLoad;
      end else if (sweep_cnt_q == '0) begin
        sweep_step  = 1'b1;
        sweep_cnt_d = SwpLoad;
        if (sweep_dir_q && (shadow_q == 4'd15)) begin
          sweep_dir_d = 1'b0;
        end else if (!sweep_dir_q && (shadow_q == 4'd0)) begin
          sweep_dir_d = 1'b1;
        end
      end else begin
        sweep_cnt_d = sweep_cnt_q - SwpW'(1);
      end
    end
  end

  always_comb begin
    want_up  = (fire && !dir_q) || (sweep_step && sweep_dir_d);
    want_dn  = (fire && dir_q) || (sweep_step && !sweep_dir_d);
    up_d     = want_up && (shadow_q != 4'd15);
    dn_d     = want_dn && (shadow_q != 4'd0);
    shadow_d = shadow_q;
    if (up_d) begin
      shadow_d = shadow_q + 4'd1;
    end else if (dn_d) begin
      shadow_d = shadow_q - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      deb_q       <= '0;
      deb_prev_q  <= '0;
      for (int i = 0; i < 2; i++) deb_cnt_q[i] <= '0;
      state_q     <= StIdle;
      dir_q       <= 1'b0;
      timer_q     <= '0;
      sweep_en_q  <= 1'b0;
      sweep_cnt_q <= '0;
      sweep_dir_q <= 1'b1;
      up_q        <= 1'b0;
      dn_q        <= 1'b0;
      shadow_q    <= 4'd1;
    end else begin
      sync1_q     <= btn_raw;
      sync2_q     <= sync1_q;
      deb_q       <= deb_d;
      deb_prev_q  <= deb_q;
      for (int i = 0; i < 2; i++) deb_cnt_q[i] <= deb_cnt_d[i];
      state_q     <= state_d;
      dir_q       <= dir_d;
      timer_q     <= timer_d;
      sweep_en_q  <= sweep_en;
      sweep_cnt_q <= sweep_cnt_d;
      sweep_dir_q <= sweep_dir_d;
      up_q        <= up_d;
      dn_q        <= dn_d;
      shadow_q    <= shadow_d;
    end
  end

  assign up          = up_q;
  assign dn          = dn_q;
  assign duty_shadow = shadow_q;
  assign sweep_dir   = sweep_dir_q;

endmodule

// File: tb/tb_duty_step_controller.sv
// Directed bench for duty_step_controller: expected pulses are queued as stimulus is applied
// and popped by a monitor whenever the DUT emits up/dn.
module tb_duty_step_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_up = 1'b0;
  logic       btn_dn = 1'b0;
  logic       sweep_en = 1'b0;
  logic       up, dn, sweep_dir;
  logic [3:0] duty_shadow;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    int         cyc;
    logic       is_up;
    logic [3:0] sh;
    logic       dir;
  } pulse_t;

  pulse_t exp_q[$];

  duty_step_controller #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (20),
    .REPEAT_RATE    (5),
    .SWEEP_PERIOD   (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_up     (btn_up),
    .btn_dn     (btn_dn),
    .sweep_en   (sweep_en),
    .up         (up),
    .dn         (dn),
    .duty_shadow(duty_shadow),
    .sweep_dir  (sweep_dir)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input int c, input logic u, input logic [3:0] s, input logic d);
    pulse_t e;
    e.cyc   = c;
    e.is_up = u;
    e.sh    = s;
    e.dir   = d;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    pulse_t e;
    if (up || dn) begin
      check("up_dn_exclusive", 32'(up & dn), 32'd0);
      check("pulse_was_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("pulse_cycle", 32'(cyc), 32'(e.cyc));
        check("pulse_is_up", 32'(up), 32'(e.is_up));
        check("pulse_shadow", 32'(duty_shadow), 32'(e.sh));
        check("pulse_sweep_dir", 32'(sweep_dir), 32'(e.dir));
      end
    end
  end

  initial begin
    int c;
    int s;
    logic d;

    // Reset state
    do_reset();
    check("rst_up", 32'(up), 32'd0);
    check("rst_dn", 32'(dn), 32'd0);
    check("rst_shadow", 32'(duty_shadow), 32'd1);
    check("rst_sweep_dir", 32'(sweep_dir), 32'd1);

    // Bounce rejection: only the final stable press steps, 7 cycles after its sampling edge
    for (int i = 0; i < 10; i++) begin
      btn_up = (i % 2 == 0);
      tick(2);
    end
    btn_up = 1'b1;
    c = cyc;
    push(c + 8, 1'b1, 4'd2, 1'b1);
    tick(15);
    btn_up = 1'b0;
    tick(20);
    check("bounce_all_seen", 32'(exp_q.size()), 32'd0);
    check("bounce_shadow", 32'(duty_shadow), 32'd2);

    // Auto-repeat up to the 15 limit
    btn_up = 1'b1;
    c = cyc;
    push(c + 8, 1'b1, 4'd3, 1'b1);
    for (int k = 4; k <= 15; k++) push(c + 28 + 5 * (k - 4), 1'b1, 4'(k), 1'b1);
    tick(120);
    btn_up = 1'b0;
    tick(20);
    check("repeat_all_seen", 32'(exp_q.size()), 32'd0);
    check("repeat_shadow_sat", 32'(duty_shadow), 32'd15);

    // Down limit
    do_reset();
    btn_dn = 1'b1;
    c = cyc;
    push(c + 8, 1'b0, 4'd0, 1'b1);
    tick(12);
    btn_dn = 1'b0;
    tick(15);
    btn_dn = 1'b1;
    tick(40);
    btn_dn = 1'b0;
    tick(15);
    check("down_all_seen", 32'(exp_q.size()), 32'd0);
    check("down_shadow_floor", 32'(duty_shadow), 32'd0);

    // Simultaneous press locks out until both released
    btn_up = 1'b1;
    btn_dn = 1'b1;
    tick(50);
    btn_dn = 1'b0;
    tick(30);
    btn_up = 1'b0;
    tick(20);
    check("simul_shadow", 32'(duty_shadow), 32'd0);
    btn_up = 1'b1;
    c = cyc;
    push(c + 8, 1'b1, 4'd1, 1'b1);
    tick(12);
    btn_up = 1'b0;
    tick(15);
    check("after_lock_all_seen", 32'(exp_q.size()), 32'd0);
    check("after_lock_shadow", 32'(duty_shadow), 32'd1);

    // Sweep: triangle walk; a button held across the end of sweep never fires
    do_reset();
    sweep_en = 1'b1;
    c = cyc;
    s = 1;
    d = 1'b1;
    for (int k = 1; k <= 39; k++) begin
      if (d && s == 15) d = 1'b0;
      else if (!d && s == 0) d = 1'b1;
      s = d ? s + 1 : s - 1;
      push(c + 1 + 8 * k, d, 4'(s), d);
    end
    tick(100);
    btn_up = 1'b1;
    tick(220);
    sweep_en = 1'b0;
    tick(30);
    btn_up = 1'b0;
    tick(20);
    check("sweep_all_seen", 32'(exp_q.size()), 32'd0);
    check("sweep_shadow_end", 32'(duty_shadow), 32'(s));
    check("sweep_dir_end", 32'(sweep_dir), 32'(d));

    // Reset mid-repeat, landing on the edge of a would-be pulse
    do_reset();
    btn_up = 1'b1;
    c = cyc;
    push(c + 8, 1'b1, 4'd2, 1'b1);
    push(c + 28, 1'b1, 4'd3, 1'b1);
    push(c + 33, 1'b1, 4'd4, 1'b1);
    tick(37);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("midrst_up", 32'(up), 32'd0);
    check("midrst_dn", 32'(dn), 32'd0);
    check("midrst_shadow", 32'(duty_shadow), 32'd1);
    check("midrst_pending", 32'(exp_q.size()), 32'd0);
    push(c + 46, 1'b1, 4'd2, 1'b1);
    tick(20);
    btn_up = 1'b0;
    tick(15);
    check("midrst_all_seen", 32'(exp_q.size()), 32'd0);
    check("midrst_shadow_end", 32'(duty_shadow), 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
